// File: rtl/day.sv
// Day-of-month BCD counter: advances on en, wraps at the month length
// (leap-aware), clamps on a shortened month and accepts validated loads.
module day #(
    parameter bit CENTURY_LEAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] month_0,
    input  logic [3:0] month_1,
    input  logic [3:0] year_0,
    input  logic [3:0] year_1,
    input  logic       set_en,
    input  logic [3:0] set_day_0,
    input  logic [3:0] set_day_1,
    output logic [3:0] day_0,
    output logic [3:0] day_1,
    output logic       dd_to_mm_en,
    output logic       set_err
);

    localparam int unsigned DW = 4;
    localparam int unsigned VW = 5;
    localparam int unsigned SW = 8;

    logic          leap;
    logic [VW-1:0] len;
    logic [DW-1:0] len_0;
    logic [DW-1:0] len_1;
    logic [VW-1:0] day_val;
    logic [SW-1:0] set_val;
    logic          set_ok;
    logic          at_end;
    logic [DW-1:0] day_0_nx;
    logic [DW-1:0] day_1_nx;
    logic          set_err_nx;

    // Divisible-by-4 test done on the BCD digits directly
    always_comb begin
        leap = 1'b0;
        if (year_1 == 4'd0 && year_0 == 4'd0) begin
            leap = CENTURY_LEAP;
        end else if (!year_1[0]) begin
            leap = (year_0 == 4'd0) || (year_0 == 4'd4) || (year_0 == 4'd8);
        end else begin
            leap = (year_0 == 4'd2) || (year_0 == 4'd6);
        end
    end

    // Unknown or non-BCD months fall through to 31 days
    always_comb begin
        len = 5'd31;
        case ({month_1, month_0})
            8'h02:                      len = leap ? 5'd29 : 5'd28;
            8'h04, 8'h06, 8'h09, 8'h11: len = 5'd30;
            default:                    len = 5'd31;
        endcase
    end

    always_comb begin
        len_1 = 4'd3;
        len_0 = 4'd1;
        case (len)
            5'd28:   begin len_1 = 4'd2; len_0 = 4'd8; end
            5'd29:   begin len_1 = 4'd2; len_0 = 4'd9; end
            5'd30:   begin len_1 = 4'd3; len_0 = 4'd0; end
            default: begin len_1 = 4'd3; len_0 = 4'd1; end
        endcase
    end

    assign day_val = VW'(day_1) * 5'd10 + VW'(day_0);
    assign set_val = SW'(set_day_1) * 8'd10 + SW'(set_day_0);
    assign set_ok  = (set_day_1 <= 4'd9) && (set_day_0 <= 4'd9) &&
                     (set_val != 8'd0) && (set_val <= SW'(len));
    assign at_end  = (day_val >= len);

    assign dd_to_mm_en = en & ~rst & ~set_en & at_end;

    // Next-day selection: load beats advance, advance beats clamp
    always_comb begin
        day_0_nx   = day_0;
        day_1_nx   = day_1;
        set_err_nx = 1'b0;
        if (set_en) begin
            if (set_ok) begin
                day_0_nx = set_day_0;
                day_1_nx = set_day_1;
            end else begin
                set_err_nx = 1'b1;
            end
        end else if (en) begin
            if (at_end) begin
                day_0_nx = 4'd1;
                day_1_nx = 4'd0;
            end else if (day_0 == 4'd9) begin
                day_0_nx = 4'd0;
                day_1_nx = day_1 + 4'd1;
            end else begin
                day_0_nx = day_0 + 4'd1;
            end
        end else if (day_val > len) begin
            day_0_nx = len_0;
            day_1_nx = len_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            day_0   <= 4'd1;
            day_1   <= 4'd0;
            set_err <= 1'b0;
        end else begin
            day_0   <= day_0_nx;
            day_1   <= day_1_nx;
            set_err <= set_err_nx;
        end
    end

endmodule

// File: doc/day.md
# day

Day-of-month counter for the century clock, directly downstream of the hour stage. It counts BCD days 01..last-day-of-month, advancing once per `en` pulse; `en` is the hour stage's `hh_to_dd_en` carry. Month length comes from the month and year digits, including the leap-year rule. It emits a carry to the month stage on the last day and accepts a validated direct day load for clock setting.

## Interface
- `CENTURY_LEAP`, default 1: year 00 is a leap year when 1 (2000-based century), common year when 0 (2100-based).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  one-cycle advance strobe (from hour stage `hh_to_dd_en`).
- `month_0`  in  4  BCD month units.
- `month_1`  in  4  BCD month tens.
- `year_0`  in  4  BCD year units.
- `year_1`  in  4  BCD year tens.
- `set_en`  in  1  load request for `set_day_1:set_day_0`.
- `set_day_0`  in  4  BCD day units to load.
- `set_day_1`  in  4  BCD day tens to load.
- `day_0`  out  4  BCD day units, registered.
- `day_1`  out  4  BCD day tens, registered.
- `dd_to_mm_en`  out  1  combinational carry to the month stage.
- `set_err`  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- **Month length (combinational):**
  - Months 01, 03, 05, 07, 08, 10, 12 have 31 days.
  - Months 04, 06, 09, 11 have 30 days.
  - Month 02 has 29 days if leap, otherwise 28.
  - Any month value outside 01..12 (including non-BCD digits) is treated as 31.
- **Leap rule, on BCD year:** the year is leap when it is divisible by 4.
  - Tens even: units must be 0, 4 or 8.
  - Tens odd: units must be 2 or 6.
  - Exception: year 00 is leap only if `CENTURY_LEAP`=1.
- **Internal compare:** all comparisons use the day value 10·day_1+day_0, a 5-bit binary value derived from the BCD digits. `len` denotes the current month length.
- **Register update priority per clock edge, highest first:**
  1. `rst`: day ← 01, `set_err` ← 0.
  2. `set_en`: if both digits are valid BCD and 1 ≤ value ≤ len, day ← value and `set_err` ← 0. Otherwise day is unchanged and `set_err` ← 1. `en` is ignored in this cycle.
  3. `en`:
     - day ≥ len: day ← 01 (wrap).
     - day_0 = 9: day_0 ← 0, day_1 ← day_1+1.
     - otherwise: day_0 ← day_0+1.
  4. No `en` and day > len: day ← len (clamp). This covers the month/year inputs being changed to a shorter month.
  5. Otherwise: hold.
- **`set_err`:** cleared on every edge not covered by rule 2's reject case. It is therefore a single-cycle pulse.
- **`dd_to_mm_en`** = `en` & ~`rst` & ~`set_en` & (day ≥ len). It is asserted in the same cycle as the wrapping `en`, so the month stage advances on the same edge as the day wrap.
- **Input sampling:** month and year inputs are sampled combinationally each cycle. When the month stage advances on the wrap edge, the new length applies from the next cycle; since day is 01 there, no clamp occurs.

## Timing
- **Reset values:** `day_1:day_0` = 0:1, `set_err` = 0. `dd_to_mm_en` = 0 while `rst` is high.
- **Increment latency:** one cycle; new day is visible the cycle after the `en` edge.
- **Carry:** `dd_to_mm_en` has zero latency (combinational from `en`, day, month, year). No registered carry.
- **Load latency:** one cycle; `set_err` rises the cycle after the rejected `set_en`.
- **Back-to-back:** `en` on consecutive cycles advances one day per cycle, with correct wrap on each.
- **Simultaneous events:**
  - `rst` with `set_en` or `en`: reset wins, no carry.
  - `set_en` with `en`: load wins, no carry, no increment. The `en` is dropped by design; the clock setter owns this.
- **Clamp:** takes one cycle and produces no carry.
- **Reset mid-count:** reset returns day to 01 on the next edge regardless of state.

## Test plan
- **Reset:** assert `rst` with day = 17 and `en` = 1 → next cycle day = 01, `dd_to_mm_en` = 0 throughout, `set_err` = 0.
- **Full 31-day month:** month 01, pulse `en` 31 times.
  - Day steps 01→09→10→…→31→01.
  - `dd_to_mm_en` is high only on the 31st pulse.
  - Check the 09→10, 19→20 and 29→30 BCD carries.
- **February, leap and common:**
  - Month 02, year 24, day 28: `en` → 29, then `en` → 01 with carry.
  - Year 23, day 28: `en` → 01 with carry.
  - Year 00 with `CENTURY_LEAP`=0: wraps after 28. With `CENTURY_LEAP`=1: wraps after 29.
  - Years 12, 16, 96 are leap; years 10, 14 are not.
- **Load validation:**
  - Month 04, set 30 → day 30, `set_err` 0.
  - Set 31 → day unchanged, `set_err` pulses one cycle.
  - Set 00 → reject.
  - Set day_0 = 0xA → reject.
  - `set_en` with `en` on day 30 (month 04) → day = loaded value, no carry.
- **Clamp:**
  - Day 31, month 01, `en` low; change month to 02, year 23 → next cycle day = 28, no carry, then holds.
  - Same with `en` high on that cycle → day = 01 and `dd_to_mm_en` high.
- **Invalid month:** month 13 (or 0x1F), day 30 → `en` → 31, next `en` → 01 with carry.
